// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register busy
// scoreboard for ID-stage hazard detection.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous reset, active-low
//   read_en    sample every read port on this edge
//   rs_addr    NREAD read addresses, port i at [i*AW +: AW]
//   rs_val     NREAD registered read values, port i at [i*XLEN +: XLEN]
//   rs_busy    NREAD registered busy flags
//   write_en   write enables for retire lanes 0 and 1
//   rd_addr    write addresses, lane i at [i*AW +: AW]
//   rd_val     write data, lane i at [i*XLEN +: XLEN]
//   mark_en    set the busy bit of mark_addr
//   mark_addr  destination being marked busy
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_val,
  output logic [NREAD-1:0]      rs_busy,
  input  logic [1:0]            write_en,
  input  logic [2*AW-1:0]       rd_addr,
  input  logic [2*XLEN-1:0]     rd_val,
  input  logic                  mark_en,
  input  logic [AW-1:0]         mark_addr
);

  localparam bit HARD_ZERO = (ZERO_REG != 0);

  logic [XLEN-1:0]       regs_q [NREGS];
  logic [XLEN-1:0]       regs_d [NREGS];
  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_d;
  logic [NREAD*XLEN-1:0] rs_val_q;
  logic [NREAD*XLEN-1:0] rs_val_d;
  logic [NREAD-1:0]      rs_busy_q;
  logic [NREAD-1:0]      rs_busy_d;

  // The next-state array doubles as the bypass source: reads index the
  // post-edge state, so lane-1-over-lane-0 and mark-over-clear priorities
  // fall out of the update order below.
  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    rs_val_d  = rs_val_q;
    rs_busy_d = rs_busy_q;

    for (int unsigned l = 0; l < 2; l++) begin
      if (write_en[l] && !(HARD_ZERO && rd_addr[l*AW +: AW] == '0)) begin
        regs_d[rd_addr[l*AW +: AW]] = rd_val[l*XLEN +: XLEN];
        busy_d[rd_addr[l*AW +: AW]] = 1'b0;
      end
    end

    if (mark_en && !(HARD_ZERO && mark_addr == '0)) begin
      busy_d[mark_addr] = 1'b1;
    end

    // With a hardwired zero register, entry 0 is never written or marked,
    // so it stays at its reset value and reads of it yield 0 / not busy.
    if (read_en) begin
      for (int unsigned p = 0; p < NREAD; p++) begin
        rs_val_d[p*XLEN +: XLEN] = regs_d[rs_addr[p*AW +: AW]];
        rs_busy_d[p]             = busy_d[rs_addr[p*AW +: AW]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q    <= '{default: '0};
      busy_q    <= '0;
      rs_val_q  <= '0;
      rs_busy_q <= '0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      rs_val_q  <= rs_val_d;
      rs_busy_q <= rs_busy_d;
    end
  end

  assign rs_val  = rs_val_q;
  assign rs_busy = rs_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives a ZERO_REG=1 and a ZERO_REG=0 instance of
// regfile_mp with identical stimulus and compares both against a
// behavioural array model of the register file and busy scoreboard.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  read_en;
  logic [NREAD*AW-1:0]   rs_addr;
  logic [1:0]            write_en;
  logic [2*AW-1:0]       rd_addr;
  logic [2*XLEN-1:0]     rd_val;
  logic                  mark_en;
  logic [AW-1:0]         mark_addr;
  logic [NREAD*XLEN-1:0] rs_val_z,  rs_val_n;
  logic [NREAD-1:0]      rs_busy_z, rs_busy_n;

  int errors = 0;
  int checks = 0;

  // Model state, index 0 = ZERO_REG=1 instance, index 1 = ZERO_REG=0.
  logic [XLEN-1:0] m_regs  [2][NREGS];
  logic            m_busy  [2][NREGS];
  logic [XLEN-1:0] m_val   [2][NREAD];
  logic            m_rbusy [2][NREAD];

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .ZERO_REG(1)) u_dut_z (
    .clk(clk), .rst(rst), .read_en(read_en), .rs_addr(rs_addr),
    .rs_val(rs_val_z), .rs_busy(rs_busy_z), .write_en(write_en),
    .rd_addr(rd_addr), .rd_val(rd_val), .mark_en(mark_en), .mark_addr(mark_addr)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .ZERO_REG(0)) u_dut_n (
    .clk(clk), .rst(rst), .read_en(read_en), .rs_addr(rs_addr),
    .rs_val(rs_val_n), .rs_busy(rs_busy_n), .write_en(write_en),
    .rd_addr(rd_addr), .rd_val(rd_val), .mark_en(mark_en), .mark_addr(mark_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[d][r] = '0;
        m_busy[d][r] = 1'b0;
      end
      for (int p = 0; p < NREAD; p++) begin
        m_val[d][p]   = '0;
        m_rbusy[d][p] = 1'b0;
      end
    end
  endtask

  // One rising edge: writes in lane order, then mark, then reads see the result.
  task automatic model_edge();
    int a;
    for (int d = 0; d < 2; d++) begin
      for (int l = 0; l < 2; l++) begin
        if (write_en[l]) begin
          a = int'(rd_addr[l*AW +: AW]);
          if (!(d == 0 && a == 0)) begin
            m_regs[d][a] = rd_val[l*XLEN +: XLEN];
            m_busy[d][a] = 1'b0;
          end
        end
      end
      if (mark_en && !(d == 0 && mark_addr == 0))
        m_busy[d][int'(mark_addr)] = 1'b1;
      if (read_en) begin
        for (int p = 0; p < NREAD; p++) begin
          a = int'(rs_addr[p*AW +: AW]);
          if (d == 0 && a == 0) begin
            m_val[d][p]   = '0;
            m_rbusy[d][p] = 1'b0;
          end else begin
            m_val[d][p]   = m_regs[d][a];
            m_rbusy[d][p] = m_busy[d][a];
          end
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int p = 0; p < NREAD; p++) begin
      check($sformatf("%s_z_val%0d", tag, p),  64'(rs_val_z[p*XLEN +: XLEN]), 64'(m_val[0][p]));
      check($sformatf("%s_z_busy%0d", tag, p), 64'(rs_busy_z[p]),             64'(m_rbusy[0][p]));
      check($sformatf("%s_n_val%0d", tag, p),  64'(rs_val_n[p*XLEN +: XLEN]), 64'(m_val[1][p]));
      check($sformatf("%s_n_busy%0d", tag, p), 64'(rs_busy_n[p]),             64'(m_rbusy[1][p]));
    end
  endtask

  task automatic drive(input logic [1:0] we, input int a0, input logic [XLEN-1:0] v0,
                       input int a1, input logic [XLEN-1:0] v1,
                       input logic me, input int ma,
                       input logic re, input int r0, input int r1);
    write_en  = we;
    rd_addr   = {AW'(a1), AW'(a0)};
    rd_val    = {v1, v0};
    mark_en   = me;
    mark_addr = AW'(ma);
    read_en   = re;
    rs_addr   = {AW'(r1), AW'(r0)};
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    model_reset();
    #1 check_outputs(tag);
    #1 rst = 1'b1;
  endtask

  function automatic int rnd_addr();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 7));
    return int'($urandom_range(0, NREGS - 1));
  endfunction

  initial begin
    drive(2'b00, 0, '0, 0, '0, 1'b0, 0, 1'b0, 0, 0);
    model_reset();
    #1 rst = 1'b0;
    #11 check_outputs("reset");
    rst = 1'b1;

    for (int i = 0; i < NREGS; i += 2) begin
      drive(2'b00, 0, '0, 0, '0, 1'b0, 0, 1'b1, i, i + 1);
      step("rst_sweep");
    end

    drive(2'b01, 5, 32'hDEADBEEF, 0, '0, 1'b0, 0, 1'b1, 5, 5);
    step("x5_wr");
    async_reset("mid_rst");
    drive(2'b00, 0, '0, 0, '0, 1'b0, 0, 1'b1, 5, 5);
    step("x5_after_rst");

    drive(2'b01, 7, 32'h12345678, 0, '0, 1'b0, 0, 1'b1, 7, 0);
    step("bypass_x7");
    drive(2'b00, 0, '0, 0, '0, 1'b0, 0, 1'b1, 7, 0);
    step("reread_x7");

    drive(2'b11, 9, 32'h1111, 9, 32'h2222, 1'b0, 0, 1'b1, 0, 9);
    step("lane_prio");
    drive(2'b00, 0, '0, 0, '0, 1'b0, 0, 1'b1, 9, 9);
    step("x9_array");

    drive(2'b00, 0, '0, 0, '0, 1'b1, 3, 1'b0, 0, 0);
    step("mark_x3");
    drive(2'b00, 0, '0, 0, '0, 1'b0, 0, 1'b1, 3, 3);
    step("busy_x3");
    drive(2'b01, 3, 32'hAA, 0, '0, 1'b1, 3, 1'b1, 3, 0);
    step("mark_wins");
    drive(2'b10, 0, '0, 3, 32'hAB, 1'b0, 0, 1'b1, 0, 3);
    step("clear_x3");

    drive(2'b01, 0, 32'hFFFF_FFFF, 0, '0, 1'b1, 0, 1'b0, 0, 0);
    step("x0_wr");
    drive(2'b00, 0, '0, 0, '0, 1'b0, 0, 1'b1, 0, 0);
    step("x0_rd");

    drive(2'b01, 4, 32'h55, 0, '0, 1'b0, 0, 1'b0, 4, 4);
    step("hold_rd");
    drive(2'b00, 0, '0, 0, '0, 1'b0, 0, 1'b1, 4, 4);
    step("x4_rd");

    for (int n = 0; n < 500; n++) begin
      drive(2'($urandom), rnd_addr(), $urandom, rnd_addr(), $urandom,
            1'($urandom), rnd_addr(), ($urandom_range(0, 3) != 0),
            rnd_addr(), rnd_addr());
      step("rand");
      if ($urandom_range(0, 63) == 0) async_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
